// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with per-register scoreboard and sequenced post-reset clear.
// Latency: reads and busy queries are combinational; writes, issues and clears take effect at the next clk_i edge.
// Backpressure: none; ready_o stays low for REG_NUM cycles after reset while the array is cleared.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   rs_addr_i/rs_data_o     NRP read ports (addr packed AW per port, data packed XLEN per port)
//   rs_busy_o               scoreboard busy flag of each read port's register
//   issue_we_i/issue_addr_i decode marks a destination register as having a pending producer
//   rd_we_i/rd_addr_i/rd_data_i  NWP writeback ports, higher index wins on address collision
//   ready_o                 array cleared, normal operation
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.

module regfile_mp_sb #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int AW      = 5,
  parameter int NRP     = 2,
  parameter int NWP     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRP*AW-1:0]   rs_addr_i,
  output logic [NRP*XLEN-1:0] rs_data_o,
  output logic [NRP-1:0]      rs_busy_o,
  input  logic                issue_we_i,
  input  logic [AW-1:0]       issue_addr_i,
  input  logic [NWP-1:0]      rd_we_i,
  input  logic [NWP*AW-1:0]   rd_addr_i,
  input  logic [NWP*XLEN-1:0] rd_data_i,
  output logic                ready_o
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0]    regs_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               run;
  logic [AW-1:0]      ra;

  assign run     = (state_q == ST_RUN);
  assign ready_o = run;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        // Counter parks on the last entry rather than wrapping.
        if (clr_cnt_q == AW'(REG_NUM - 1)) state_d = ST_RUN;
        else                              clr_cnt_d = clr_cnt_q + 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ---------------- Storage (no reset: cleared one entry per cycle) ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (!run) begin
        regs_q[clr_cnt_q] <= '0;
      end else begin
        // Later loop iterations override earlier ones: higher port index wins.
        for (int k = 0; k < NWP; k++) begin
          if (rd_we_i[k] && (rd_addr_i[k*AW +: AW] != '0))
            regs_q[rd_addr_i[k*AW +: AW]] <= rd_data_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // ---------------- Scoreboard ----------------
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int k = 0; k < NWP; k++) begin
        if (rd_we_i[k]) busy_d[rd_addr_i[k*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a new producer outranks a same-cycle writeback.
      if (issue_we_i && (issue_addr_i != '0)) busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // ---------------- Read ports ----------------
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    ra        = '0;
    for (int p = 0; p < NRP; p++) begin
      ra = rs_addr_i[p*AW +: AW];
      rs_data_o[p*XLEN +: XLEN] = regs_q[ra];
      rs_busy_o[p]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWP; k++) begin
        if (rd_we_i[k] && (rd_addr_i[k*AW +: AW] == ra)) begin
          rs_data_o[p*XLEN +: XLEN] = rd_data_i[k*XLEN +: XLEN];
          // Value is being produced now; only a same-cycle reissue keeps it busy.
          rs_busy_o[p]              = issue_we_i && (issue_addr_i == ra);
        end
      end
`endif
      if (!run || (ra == '0)) begin
        rs_data_o[p*XLEN +: XLEN] = '0;
        rs_busy_o[p]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int AW      = 5;
  localparam int NRP     = 2;
  localparam int NWP     = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NRP*AW-1:0]   rs_addr_i;
  logic [NRP*XLEN-1:0] rs_data_o;
  logic [NRP-1:0]      rs_busy_o;
  logic                issue_we_i;
  logic [AW-1:0]       issue_addr_i;
  logic [NWP-1:0]      rd_we_i;
  logic [NWP*AW-1:0]   rd_addr_i;
  logic [NWP*XLEN-1:0] rd_data_i;
  logic                ready_o;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [XLEN-1:0] m_mem  [REG_NUM];
  bit              m_busy [REG_NUM];
  bit              m_ready;
  int              m_init_cycles;

  regfile_mp_sb #(.XLEN(XLEN), .REG_NUM(REG_NUM), .AW(AW), .NRP(NRP), .NWP(NWP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o),
    .rs_busy_o(rs_busy_o), .issue_we_i(issue_we_i), .issue_addr_i(issue_addr_i),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------- reference model ----------
  function automatic logic [XLEN-1:0] exp_data(int p);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = rs_addr_i[p*AW +: AW];
    if (!m_ready || a == 0) return '0;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NWP; k++)
      if (rd_we_i[k] && rd_addr_i[k*AW +: AW] == a) v = rd_data_i[k*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic bit exp_busy(int p);
    logic [AW-1:0] a;
    bit b;
    a = rs_addr_i[p*AW +: AW];
    if (!m_ready || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NWP; k++)
      if (rd_we_i[k] && rd_addr_i[k*AW +: AW] == a) b = issue_we_i && (issue_addr_i == a);
`endif
    return b;
  endfunction

  task automatic model_edge();
    if (rst_i) begin
      m_ready = 0;
      m_init_cycles = 0;
      for (int r = 0; r < REG_NUM; r++) m_busy[r] = 0;
    end else if (!m_ready) begin
      m_init_cycles++;
      if (m_init_cycles == REG_NUM) begin
        m_ready = 1;
        for (int r = 0; r < REG_NUM; r++) m_mem[r] = '0;
      end
    end else begin
      for (int k = 0; k < NWP; k++) begin
        if (rd_we_i[k]) begin
          if (rd_addr_i[k*AW +: AW] != 0) m_mem[rd_addr_i[k*AW +: AW]] = rd_data_i[k*XLEN +: XLEN];
          m_busy[rd_addr_i[k*AW +: AW]] = 0;
        end
      end
      if (issue_we_i && issue_addr_i != 0) m_busy[issue_addr_i] = 1;
    end
  endtask

  // Advance one clock: model follows the edge, then return to the falling edge.
  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    rst_i = 0; issue_we_i = 0; issue_addr_i = '0;
    rd_we_i = '0; rd_addr_i = '0; rd_data_i = '0; rs_addr_i = '0;
  endtask

  task automatic wr(int port, int addr, logic [XLEN-1:0] data);
    rd_we_i[port] = 1'b1;
    rd_addr_i[port*AW +: AW] = AW'(addr);
    rd_data_i[port*XLEN +: XLEN] = data;
  endtask

  task automatic pulse_reset();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  // ---------- tests ----------
  task automatic test_reset();
    idle_inputs();
    pulse_reset();
    for (int i = 0; i <= REG_NUM; i++) begin
      rs_addr_i = {AW'(i % REG_NUM), AW'((i + 3) % REG_NUM)};
      #1;
      checks++;
      if (ready_o !== (i == REG_NUM)) $display("FAIL reset_ready cycle %0d: got %b want %b", i, ready_o, (i == REG_NUM));
      else passed++;
      if (i < REG_NUM) begin
        checks++;
        if (rs_data_o !== '0 || rs_busy_o !== '0)
          $display("FAIL reset_outputs_gated cycle %0d: data %h busy %b want 0", i, rs_data_o, rs_busy_o);
        else passed++;
        tick();
      end
    end
    for (int r = 0; r < REG_NUM; r += 2) begin
      rs_addr_i = {AW'(r + 1), AW'(r)};
      #1;
      checks++;
      if (rs_data_o !== '0 || rs_busy_o !== '0)
        $display("FAIL reset_regs_zero x%0d/x%0d: data %h busy %b want 0", r, r + 1, rs_data_o, rs_busy_o);
      else passed++;
      tick();
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    wr(0, 5, 32'h1234);
    tick();
    idle_inputs();
    rs_addr_i[0 +: AW] = 5;
    #1;
    checks++;
    if (rs_data_o[0 +: XLEN] !== 32'h1234) $display("FAIL write_read_x5: got %h want %h", rs_data_o[0 +: XLEN], 32'h1234);
    else passed++;
    wr(0, 0, 32'hFFFF);
    tick();
    idle_inputs();
    rs_addr_i = {AW'(0), AW'(0)};
    #1;
    checks++;
    if (rs_data_o !== '0) $display("FAIL x0_hardwired: got %h want 0", rs_data_o);
    else passed++;
  endtask

  task automatic test_port_priority();
    idle_inputs();
    wr(0, 7, 32'hAAAA);
    wr(1, 7, 32'h5555);
    tick();
    idle_inputs();
    rs_addr_i[AW +: AW] = 7;
    #1;
    checks++;
    if (rs_data_o[XLEN +: XLEN] !== 32'h5555) $display("FAIL port_priority_x7: got %h want %h", rs_data_o[XLEN +: XLEN], 32'h5555);
    else passed++;
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    issue_we_i = 1; issue_addr_i = 9;
    tick();
    idle_inputs();
    rs_addr_i[0 +: AW] = 9;
    #1;
    checks++;
    if (rs_busy_o[0] !== 1'b1) $display("FAIL sb_issue_sets: got %b want 1", rs_busy_o[0]);
    else passed++;
    wr(1, 9, 32'h42);
    #1;
    checks++;
    if (rs_busy_o[0] !== exp_busy(0)) $display("FAIL sb_same_cycle_write: got %b want %b", rs_busy_o[0], exp_busy(0));
    else passed++;
    tick();
    idle_inputs();
    rs_addr_i[0 +: AW] = 9;
    #1;
    checks++;
    if (rs_busy_o[0] !== 1'b0 || rs_data_o[0 +: XLEN] !== 32'h42)
      $display("FAIL sb_write_clears: busy %b data %h want 0 / 42", rs_busy_o[0], rs_data_o[0 +: XLEN]);
    else passed++;
    issue_we_i = 1; issue_addr_i = 9;
    wr(0, 9, 32'h43);
    tick();
    idle_inputs();
    rs_addr_i[0 +: AW] = 9;
    #1;
    checks++;
    if (rs_busy_o[0] !== 1'b1) $display("FAIL sb_set_wins: got %b want 1", rs_busy_o[0]);
    else passed++;
    issue_we_i = 1; issue_addr_i = 0;
    tick();
    idle_inputs();
    rs_addr_i[0 +: AW] = 0;
    #1;
    checks++;
    if (rs_busy_o[0] !== 1'b0) $display("FAIL sb_x0_never_busy: got %b want 0", rs_busy_o[0]);
    else passed++;
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] want;
    idle_inputs();
    wr(0, 3, 32'h1111);
    tick();
    idle_inputs();
    wr(0, 3, 32'hBEEF);
    rs_addr_i[AW +: AW] = 3;
`ifdef REGFILE_BYPASS_EN
    want = 32'hBEEF;
`else
    want = 32'h1111;
`endif
    #1;
    checks++;
    if (rs_data_o[XLEN +: XLEN] !== want) $display("FAIL same_cycle_read_x3: got %h want %h", rs_data_o[XLEN +: XLEN], want);
    else passed++;
    tick();
    idle_inputs();
    rs_addr_i[AW +: AW] = 3;
    #1;
    checks++;
    if (rs_data_o[XLEN +: XLEN] !== 32'hBEEF) $display("FAIL after_write_x3: got %h want %h", rs_data_o[XLEN +: XLEN], 32'hBEEF);
    else passed++;
  endtask

  task automatic count_init(string tag);
    for (int i = 0; i <= REG_NUM; i++) begin
      #1;
      checks++;
      if (ready_o !== (i == REG_NUM)) $display("FAIL %s_ready cycle %0d: got %b want %b", tag, i, ready_o, (i == REG_NUM));
      else passed++;
      if (i < REG_NUM) tick();
    end
  endtask

  task automatic test_reset_restart();
    idle_inputs();
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      wr(1, 4, 32'hDEAD);       // must be ignored during clearing
      issue_we_i = 1; issue_addr_i = 6;
      tick();
    end
    idle_inputs();
    pulse_reset();
    count_init("midinit_restart");
    rs_addr_i = {AW'(6), AW'(4)};
    #1;
    checks++;
    if (rs_data_o !== '0 || rs_busy_o !== '0) $display("FAIL init_ignores_writes: data %h busy %b want 0", rs_data_o, rs_busy_o);
    else passed++;
    idle_inputs();
    issue_we_i = 1; issue_addr_i = 12;
    wr(0, 20, 32'h77);
    tick();
    idle_inputs();
    rs_addr_i = {AW'(20), AW'(12)};
    #1;
    checks++;
    if (rs_busy_o[0] !== 1'b1 || rs_data_o[XLEN +: XLEN] !== 32'h77)
      $display("FAIL run_prereset: busy %b data %h want 1 / 77", rs_busy_o[0], rs_data_o[XLEN +: XLEN]);
    else passed++;
    pulse_reset();
    count_init("run_restart");
    rs_addr_i = {AW'(20), AW'(12)};
    #1;
    checks++;
    if (rs_data_o !== '0 || rs_busy_o !== '0) $display("FAIL run_restart_cleared: data %h busy %b want 0", rs_data_o, rs_busy_o);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      for (int k = 0; k < NWP; k++)
        if ($urandom_range(0, 2) != 0) wr(k, $urandom_range(0, 7), $urandom);
      issue_we_i   = ($urandom_range(0, 3) == 0);
      issue_addr_i = AW'($urandom_range(0, 7));
      for (int p = 0; p < NRP; p++) rs_addr_i[p*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < NRP; p++) begin
        checks++;
        if (rs_data_o[p*XLEN +: XLEN] !== exp_data(p) || rs_busy_o[p] !== exp_busy(p)) begin
          if (errs < 10)
            $display("FAIL random cycle %0d port %0d: data %h busy %b want %h / %b", c, p,
                     rs_data_o[p*XLEN +: XLEN], rs_busy_o[p], exp_data(p), exp_busy(p));
          errs++;
        end else passed++;
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    m_ready = 0;
    m_init_cycles = 0;
    for (int r = 0; r < REG_NUM; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
    @(negedge clk_i);
    test_reset();
    test_write_read();
    test_port_priority();
    test_scoreboard();
    test_bypass();
    test_reset_restart();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
